// File: rtl/minibyte_bus_responder.sv
// minibyte_bus_responder: memory/IO target for the minibyte CPU external bus.
// Provides a small RAM plus four memory-mapped IO registers (GPIO out, synchronized
// GPIO in, a free-running cycle counter and a sticky contention status), and runs a
// turnaround state machine that decides when the responder may drive the shared
// data path after the CPU has released it.

module minibyte_bus_responder #(
    parameter int RAM_DEPTH   = 64,
    parameter int TURN_CYCLES = 1
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [6:0] addr_in,
    input  logic [7:0] data_in,
    input  logic       we_in,
    input  logic       cpu_drive_in,
    input  logic [7:0] gpio_in,
    output logic [7:0] data_out,
    output logic       drive_out,
    output logic [7:0] gpio_out,
    output logic       contention_out
);

    // Fixed IO register addresses at the top of the 7-bit map.
    localparam logic [6:0] ADDR_GPIO_OUT = 7'h7C;
    localparam logic [6:0] ADDR_GPIO_IN  = 7'h7D;
    localparam logic [6:0] ADDR_CYCLE    = 7'h7E;
    localparam logic [6:0] ADDR_STATUS   = 7'h7F;

    // RAM storage is rounded up to a power of two so the low address bits index it
    // directly; the range check against RAM_LIMIT keeps the extra slots unreachable.
    localparam int         RAM_AW    = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int         RAM_SLOTS = 1 << RAM_AW;
    localparam logic [6:0] RAM_LIMIT = 7'(RAM_DEPTH);

    // Turn counter starts at TURN_CYCLES-1 and counts down to zero in TURN.
    localparam logic [1:0] TURN_LOAD = 2'(TURN_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TURN  = 2'd1,
        DRIVE = 2'd2
    } bus_state_t;

    bus_state_t        state;
    bus_state_t        next_state;
    logic [1:0]        turn_cnt;
    logic [1:0]        next_turn_cnt;
    logic              bus_quiet;

    logic [7:0]        mem [RAM_SLOTS];
    logic [RAM_AW-1:0] ram_idx;
    logic              ram_hit;

    logic [7:0]        cycle_cnt;
    logic [7:0]        gpio_sync1;
    logic [7:0]        gpio_sync2;
    logic [7:0]        read_data;
    logic              set_req;
    logic              clear_req;

    // The bus is quiet when the CPU neither drives the data path nor writes.
    assign bus_quiet = !cpu_drive_in && !we_in;

    assign ram_idx = addr_in[RAM_AW-1:0];
    assign ram_hit = (addr_in < RAM_LIMIT);

    // Both drivers enabled at once is contention; a STATUS write with bit0 set asks to clear it.
    assign set_req   = drive_out && cpu_drive_in;
    assign clear_req = we_in && (addr_in == ADDR_STATUS) && data_in[0];

    // Turnaround state register together with its dead-cycle counter.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state    <= IDLE;
            turn_cnt <= 2'd0;
        end else begin
            state    <= next_state;
            turn_cnt <= next_turn_cnt;
        end
    end

    // Next-state logic: any CPU activity sends us back to IDLE; a quiet bus walks IDLE->TURN->DRIVE.
    always_comb begin
        next_state    = state;
        next_turn_cnt = turn_cnt;
        case (state)
            IDLE: begin
                if (bus_quiet) begin
                    next_state    = TURN;
                    next_turn_cnt = TURN_LOAD;
                end
            end
            TURN: begin
                if (!bus_quiet) begin
                    next_state = IDLE;
                end else if (turn_cnt == 2'd0) begin
                    next_state = DRIVE;
                end else begin
                    next_turn_cnt = turn_cnt - 2'd1;
                end
            end
            DRIVE: begin
                if (!bus_quiet) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output enable comes straight from the state register, so it is glitch-free.
    always_comb begin
        drive_out = (state == DRIVE);
    end

    // RAM write port; RAM is never cleared and writes are suppressed in a reset cycle.
    always_ff @(posedge clk_in) begin
        if (rst_in && we_in && ram_hit) begin
            mem[ram_idx] <= data_in;
        end
    end

    // GPIO output register, written through address 0x7C.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            gpio_out <= 8'h00;
        end else if (we_in && (addr_in == ADDR_GPIO_OUT)) begin
            gpio_out <= data_in;
        end
    end

    // Two-flop synchronizer for the asynchronous GPIO inputs.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            gpio_sync1 <= 8'h00;
            gpio_sync2 <= 8'h00;
        end else begin
            gpio_sync1 <= gpio_in;
            gpio_sync2 <= gpio_sync1;
        end
    end

    // Free-running cycle counter that wraps naturally from 0xFF to 0x00.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            cycle_cnt <= 8'h00;
        end else begin
            cycle_cnt <= cycle_cnt + 8'd1;
        end
    end

    // Sticky contention flag; a new contention event beats a simultaneous clear.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            contention_out <= 1'b0;
        end else if (set_req) begin
            contention_out <= 1'b1;
        end else if (clear_req) begin
            contention_out <= 1'b0;
        end
    end

    // Address decode for reads; unmapped locations read as zero.
    always_comb begin
        read_data = 8'h00;
        if (ram_hit) begin
            read_data = mem[ram_idx];
        end else begin
            case (addr_in)
                ADDR_GPIO_OUT: read_data = gpio_out;
                ADDR_GPIO_IN:  read_data = gpio_sync2;
                ADDR_CYCLE:    read_data = cycle_cnt;
                ADDR_STATUS:   read_data = {7'b0, contention_out};
                default:       read_data = 8'h00;
            endcase
        end
    end

    // Read data register: captures the addressed value on read cycles and holds during writes.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            data_out <= 8'h00;
        end else if (!we_in) begin
            data_out <= read_data;
        end
    end

endmodule

// File: tb/tb_minibyte_bus_responder.sv
// Testbench for minibyte_bus_responder: directed vector table for the documented
// corner cases plus randomized traffic compared against a behavioural model.

module tb_minibyte_bus_responder;

    localparam int RAM_DEPTH   = 64;
    localparam int TURN_CYCLES = 2;

    logic       clk;
    logic       rst_n;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       we;
    logic       cpu_drive;
    logic [7:0] gpio;
    logic [7:0] data_out;
    logic       drive_out;
    logic [7:0] gpio_out;
    logic       contention_out;

    int checks   = 0;
    int failures = 0;

    minibyte_bus_responder #(
        .RAM_DEPTH  (RAM_DEPTH),
        .TURN_CYCLES(TURN_CYCLES)
    ) dut (
        .clk_in        (clk),
        .rst_in        (rst_n),
        .addr_in       (addr),
        .data_in       (wdata),
        .we_in         (we),
        .cpu_drive_in  (cpu_drive),
        .gpio_in       (gpio),
        .data_out      (data_out),
        .drive_out     (drive_out),
        .gpio_out      (gpio_out),
        .contention_out(contention_out)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state. The turnaround is modelled as "number of consecutive
    // quiet edges": the responder drives once that run exceeds TURN_CYCLES.
    logic [7:0] m_ram [0:127];
    logic [7:0] m_dout;
    logic [7:0] m_gpo;
    logic       m_cont;
    int         m_cyc;
    int         m_quiet;
    logic [7:0] gpio_hist [$];

    function automatic logic [7:0] model_read(input logic [6:0] a);
        if (int'(a) < RAM_DEPTH) return m_ram[a];
        if (a == 7'h7C) return m_gpo;
        if (a == 7'h7D) return gpio_hist[0];
        if (a == 7'h7E) return 8'(m_cyc);
        if (a == 7'h7F) return {7'b0, m_cont};
        return 8'h00;
    endfunction

    function automatic logic model_drive();
        return (m_quiet > TURN_CYCLES);
    endfunction

    task automatic model_edge();
        logic set_c;
        logic clr_c;
        if (!rst_n) begin
            m_dout  = 8'h00;
            m_gpo   = 8'h00;
            m_cont  = 1'b0;
            m_cyc   = 0;
            m_quiet = 0;
            gpio_hist.delete();
            gpio_hist.push_back(8'h00);
            gpio_hist.push_back(8'h00);
        end else begin
            set_c = model_drive() && cpu_drive;
            clr_c = we && (addr == 7'h7F) && wdata[0];
            if (!we) begin
                m_dout = model_read(addr);
            end else begin
                if (int'(addr) < RAM_DEPTH) m_ram[addr] = wdata;
                if (addr == 7'h7C) m_gpo = wdata;
            end
            m_cont = set_c || (m_cont && !clr_c);
            m_cyc  = (m_cyc + 1) % 256;
            gpio_hist.push_back(gpio);
            void'(gpio_hist.pop_front());
            if (!cpu_drive && !we) m_quiet = (m_quiet < 100) ? m_quiet + 1 : m_quiet;
            else m_quiet = 0;
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        check("model.data_out", data_out, m_dout);
        check("model.drive_out", {7'b0, drive_out}, {7'b0, model_drive()});
        check("model.gpio_out", gpio_out, m_gpo);
        check("model.contention", {7'b0, contention_out}, {7'b0, m_cont});
    endtask

    task automatic applyStimulus(input logic r, input logic [6:0] a, input logic [7:0] d,
                                 input logic w, input logic c, input logic [7:0] g);
        rst_n     = r;
        addr      = a;
        wdata     = d;
        we        = w;
        cpu_drive = c;
        gpio      = g;
        @(posedge clk);
        model_edge();
        #1;
        checkOutput();
    endtask

    typedef struct {
        logic [6:0] addr;
        logic [7:0] data;
        logic       we;
        logic       cpu;
        logic [7:0] gpio;
        logic [7:0] exp_data;
        logic       exp_drive;
        logic [7:0] exp_gpo;
        logic       exp_cont;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(input logic [6:0] a, input logic [7:0] d, input logic w,
                                input logic c, input logic [7:0] g, input logic [7:0] ed,
                                input logic edrv, input logic [7:0] egpo, input logic ec);
        vec_t v;
        v.addr = a; v.data = d; v.we = w; v.cpu = c; v.gpio = g;
        v.exp_data = ed; v.exp_drive = edrv; v.exp_gpo = egpo; v.exp_cont = ec;
        return v;
    endfunction

    // Watchdog so the run always ends even if the flow stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic       cpu_r;
        logic [7:0] g_r;
        logic [6:0] a_r;
        int         sel;

        // Directed vectors: each row is one edge, expectations are values after that edge.
        //                addr   data   we    cpu   gpio   data   drv   gpo    cont
        vecs.push_back(mk(7'h7E, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0));
        vecs.push_back(mk(7'h7E, 8'h00, 1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 8'h00, 1'b0));
        vecs.push_back(mk(7'h7E, 8'h00, 1'b0, 1'b1, 8'h00, 8'h02, 1'b0, 8'h00, 1'b0));
        vecs.push_back(mk(7'h10, 8'hA5, 1'b1, 1'b1, 8'h00, 8'h02, 1'b0, 8'h00, 1'b0));
        vecs.push_back(mk(7'h10, 8'h00, 1'b0, 1'b1, 8'h00, 8'hA5, 1'b0, 8'h00, 1'b0));
        vecs.push_back(mk(7'h10, 8'h3C, 1'b1, 1'b1, 8'h00, 8'hA5, 1'b0, 8'h00, 1'b0));
        vecs.push_back(mk(7'h10, 8'h00, 1'b0, 1'b1, 8'h00, 8'h3C, 1'b0, 8'h00, 1'b0));
        vecs.push_back(mk(7'h3F, 8'h55, 1'b1, 1'b1, 8'h00, 8'h3C, 1'b0, 8'h00, 1'b0));
        vecs.push_back(mk(7'h40, 8'h55, 1'b1, 1'b1, 8'h00, 8'h3C, 1'b0, 8'h00, 1'b0));
        vecs.push_back(mk(7'h3F, 8'h00, 1'b0, 1'b1, 8'h00, 8'h55, 1'b0, 8'h00, 1'b0));
        vecs.push_back(mk(7'h40, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0));
        vecs.push_back(mk(7'h7D, 8'hFF, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0));
        vecs.push_back(mk(7'h7D, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0));
        vecs.push_back(mk(7'h7C, 8'h81, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 8'h81, 1'b0));
        vecs.push_back(mk(7'h7C, 8'h00, 1'b0, 1'b1, 8'h00, 8'h81, 1'b0, 8'h81, 1'b0));
        vecs.push_back(mk(7'h7F, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h81, 1'b0));
        vecs.push_back(mk(7'h7D, 8'h00, 1'b0, 1'b1, 8'hC3, 8'h00, 1'b0, 8'h81, 1'b0));
        vecs.push_back(mk(7'h7D, 8'h00, 1'b0, 1'b1, 8'hC3, 8'h00, 1'b0, 8'h81, 1'b0));
        vecs.push_back(mk(7'h7D, 8'h00, 1'b0, 1'b1, 8'hC3, 8'hC3, 1'b0, 8'h81, 1'b0));
        vecs.push_back(mk(7'h7C, 8'h00, 1'b0, 1'b0, 8'hC3, 8'h81, 1'b0, 8'h81, 1'b0));
        vecs.push_back(mk(7'h7C, 8'h00, 1'b0, 1'b0, 8'hC3, 8'h81, 1'b0, 8'h81, 1'b0));
        vecs.push_back(mk(7'h7C, 8'h00, 1'b0, 1'b0, 8'hC3, 8'h81, 1'b1, 8'h81, 1'b0));
        vecs.push_back(mk(7'h7C, 8'h00, 1'b0, 1'b1, 8'hC3, 8'h81, 1'b0, 8'h81, 1'b1));
        vecs.push_back(mk(7'h7F, 8'h00, 1'b0, 1'b1, 8'hC3, 8'h01, 1'b0, 8'h81, 1'b1));
        vecs.push_back(mk(7'h7F, 8'h01, 1'b1, 1'b1, 8'hC3, 8'h01, 1'b0, 8'h81, 1'b0));
        vecs.push_back(mk(7'h7C, 8'h00, 1'b0, 1'b0, 8'hC3, 8'h81, 1'b0, 8'h81, 1'b0));
        vecs.push_back(mk(7'h7C, 8'h00, 1'b0, 1'b0, 8'hC3, 8'h81, 1'b0, 8'h81, 1'b0));
        vecs.push_back(mk(7'h7C, 8'h00, 1'b0, 1'b0, 8'hC3, 8'h81, 1'b1, 8'h81, 1'b0));
        vecs.push_back(mk(7'h7F, 8'h01, 1'b1, 1'b1, 8'hC3, 8'h81, 1'b0, 8'h81, 1'b1));
        vecs.push_back(mk(7'h7F, 8'h00, 1'b0, 1'b1, 8'hC3, 8'h01, 1'b0, 8'h81, 1'b1));

        // Reset held for two cycles with random inputs.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 7'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
            check($sformatf("reset%0d.data_out", i), data_out, 8'h00);
            check($sformatf("reset%0d.drive_out", i), {7'b0, drive_out}, 8'h00);
            check($sformatf("reset%0d.gpio_out", i), gpio_out, 8'h00);
            check($sformatf("reset%0d.contention", i), {7'b0, contention_out}, 8'h00);
        end

        // Directed table.
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(1'b1, vecs[i].addr, vecs[i].data, vecs[i].we, vecs[i].cpu, vecs[i].gpio);
            check($sformatf("vec%0d.data_out", i), data_out, vecs[i].exp_data);
            check($sformatf("vec%0d.drive_out", i), {7'b0, drive_out}, {7'b0, vecs[i].exp_drive});
            check($sformatf("vec%0d.gpio_out", i), gpio_out, vecs[i].exp_gpo);
            check($sformatf("vec%0d.contention", i), {7'b0, contention_out}, {7'b0, vecs[i].exp_cont});
        end

        // Reset in the middle of writes: the RAM and GPIO writes in the reset cycle are dropped.
        applyStimulus(1'b1, 7'h20, 8'h11, 1'b1, 1'b1, 8'h00);
        applyStimulus(1'b0, 7'h20, 8'h77, 1'b1, 1'b1, 8'h00);
        applyStimulus(1'b0, 7'h7C, 8'h5A, 1'b1, 1'b1, 8'h00);
        check("midreset.gpio_out", gpio_out, 8'h00);
        applyStimulus(1'b1, 7'h20, 8'h00, 1'b0, 1'b1, 8'h00);
        check("midreset.ram_kept", data_out, 8'h11);

        // Load every RAM byte so random reads have known contents.
        for (int i = 0; i < RAM_DEPTH; i++) begin
            applyStimulus(1'b1, 7'(i), 8'($urandom), 1'b1, 1'b1, 8'h00);
        end

        // Randomized traffic, biased toward IO registers and bus turnaround activity.
        cpu_r = 1'b1;
        g_r   = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 5)       a_r = 7'($urandom_range(0, RAM_DEPTH - 1));
            else if (sel == 5) a_r = 7'($urandom_range(RAM_DEPTH, 123));
            else               a_r = 7'($urandom_range(124, 127));
            if ($urandom_range(0, 4) == 0) cpu_r = ~cpu_r;
            if ($urandom_range(0, 7) == 0) g_r = 8'($urandom);
            applyStimulus(($urandom_range(0, 199) != 0), a_r, 8'($urandom),
                          ($urandom_range(0, 3) == 0), cpu_r, g_r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
